// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two sources from the register file, stalls on
// pending writes tracked in a scoreboard, forwards same-cycle writeback data.
module operand_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_ra,
  input  logic [ADDR_WIDTH-1:0] in_rb,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wr,
  output logic                  rf_read_a,
  output logic                  rf_read_b,
  output logic [ADDR_WIDTH-1:0] rf_a_addr,
  output logic [ADDR_WIDTH-1:0] rf_b_addr,
  input  logic [DATA_WIDTH-1:0] rf_a_data,
  input  logic [DATA_WIDTH-1:0] rf_b_data,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_w_addr,
  output logic [DATA_WIDTH-1:0] rf_d_in,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_wr,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid is never dropped before the transfer completes.

  localparam int NREG = 1 << ADDR_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] ra_q;
  logic [ADDR_WIDTH-1:0] rb_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  wr_q;
  logic [NREG-1:0]       sb;
  logic [NREG-1:0]       sb_nxt;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] cap_a;
  logic [DATA_WIDTH-1:0] cap_b;
  logic                  wb_hit_a;
  logic                  wb_hit_b;
  logic                  busy_a;
  logic                  busy_b;
  logic                  accept;
  logic                  fetch_go;
  logic                  handshake;

  // Writeback goes straight to the register file; r0 is never written.
  assign rf_write  = wb_valid && (wb_addr != '0);
  assign rf_w_addr = wb_addr;
  assign rf_d_in   = wb_data;

  assign rf_a_addr = ra_q;
  assign rf_b_addr = rb_q;

  // A writeback arriving this cycle releases its register immediately.
  assign wb_hit_a = wb_valid && (wb_addr == ra_q);
  assign wb_hit_b = wb_valid && (wb_addr == rb_q);
  assign busy_a   = (ra_q != '0) && sb[ra_q] && !wb_hit_a;
  assign busy_b   = (rb_q != '0) && sb[rb_q] && !wb_hit_b;

  assign accept    = (state == IDLE) && in_valid;
  assign fetch_go  = (state == FETCH) && !busy_a && !busy_b;
  assign handshake = (state == VALID) && out_ready;

  assign in_ready  = (state == IDLE);
  assign rf_read_a = fetch_go;
  assign rf_read_b = fetch_go;
  assign out_valid = (state == VALID);
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_rd    = rd_q;
  assign out_wr    = wr_q;
  assign dbg_state = state;

  always_comb begin
    cap_a = rf_a_data;
    if (ra_q == '0) begin
      cap_a = '0;
    end else if (wb_hit_a) begin
      cap_a = wb_data;
    end
  end

  always_comb begin
    cap_b = rf_b_data;
    if (rb_q == '0) begin
      cap_b = '0;
    end else if (wb_hit_b) begin
      cap_b = wb_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = FETCH;
      FETCH:   if (fetch_go) state_nxt = VALID;
      VALID:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear first so that a same-cycle set of the same register wins.
  always_comb begin
    sb_nxt = sb;
    if (wb_valid) begin
      sb_nxt[wb_addr] = 1'b0;
    end
    if (handshake && wr_q && (rd_q != '0)) begin
      sb_nxt[rd_q] = 1'b1;
    end
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sb    <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rd_q  <= '0;
      wr_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nxt;
      sb    <= sb_nxt;
      if (accept) begin
        ra_q <= in_ra;
        rb_q <= in_rb;
        rd_q <= in_rd;
        wr_q <= in_wr;
      end
      if (fetch_go) begin
        a_q <= cap_a;
        b_q <= cap_b;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model, directed scenarios and a
// transaction-level reference model compared on every falling clock edge.
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_ra;
  logic [4:0]  in_rb;
  logic [4:0]  in_rd;
  logic        in_wr;
  logic        rf_read_a;
  logic        rf_read_b;
  logic [4:0]  rf_a_addr;
  logic [4:0]  rf_b_addr;
  logic [15:0] rf_a_data;
  logic [15:0] rf_b_data;
  logic        rf_write;
  logic [4:0]  rf_w_addr;
  logic [15:0] rf_d_in;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [4:0]  out_rd;
  logic        out_wr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int str_a = 0;
  int str_b = 0;

  operand_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_wr(in_wr),
    .rf_read_a(rf_read_a), .rf_read_b(rf_read_b),
    .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr),
    .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
    .rf_write(rf_write), .rf_w_addr(rf_w_addr), .rf_d_in(rf_d_in),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wr(out_wr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  logic [15:0] rf_mem [32];
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 16'hA000 | 16'(i);
  end
  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_w_addr] <= rf_d_in;
  end
  assign rf_a_data = rf_mem[rf_a_addr];
  assign rf_b_data = rf_mem[rf_b_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural values, pending-write set, one instruction waiting for its
  // operands, and a queue of expected results {a, b, rd, wr}.
  logic [15:0] arch [32];
  bit          pend [32];
  bit          have_fetch;
  logic [4:0]  f_ra, f_rb, f_rd;
  logic        f_wr;
  logic [37:0] exp_q [$];

  initial begin
    for (int i = 0; i < 32; i++) begin
      arch[i] = 16'hA000 | 16'(i);
      pend[i] = 0;
    end
    have_fetch = 0;
  end

  function automatic logic [15:0] model_val(input logic [4:0] r);
    if (r == 5'd0) return 16'h0000;
    if (wb_valid && wb_addr == r) return wb_data;
    return arch[r];
  endfunction

  function automatic bit model_busy(input logic [4:0] r);
    return (r != 5'd0) && pend[r] && !(wb_valid && wb_addr == r);
  endfunction

  always @(negedge clk) begin
    logic        exp_strobe;
    logic        exp_ready;
    logic        retire;
    logic [37:0] e;
    if (!reset) begin
      have_fetch = 0;
      exp_q.delete();
      for (int i = 0; i < 32; i++) pend[i] = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_read_a", rf_read_a, 0);
      chk("rst_read_b", rf_read_b, 0);
      chk("rst_out_a", out_a, 0);
    end else begin
      if (rf_read_a) str_a++;
      if (rf_read_b) str_b++;
      exp_strobe = have_fetch && !model_busy(f_ra) && !model_busy(f_rb);
      exp_ready  = !have_fetch && (exp_q.size() == 0);
      chk("in_ready", in_ready, exp_ready);
      chk("rf_read_a", rf_read_a, exp_strobe);
      chk("rf_read_b", rf_read_b, exp_strobe);
      chk("rf_write", rf_write, wb_valid && wb_addr != 5'd0);
      chk("rf_w_addr", rf_w_addr, wb_addr);
      chk("rf_d_in", rf_d_in, wb_data);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (have_fetch) begin
        chk("rf_a_addr", rf_a_addr, f_ra);
        chk("rf_b_addr", rf_b_addr, f_rb);
      end
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("out_a", out_a, e[37:22]);
        chk("out_b", out_b, e[21:6]);
        chk("out_rd", out_rd, e[5:1]);
        chk("out_wr", out_wr, e[0]);
      end
      // state that will hold after the coming rising edge
      retire = (exp_q.size() != 0) && out_ready;
      e = '0;
      if (retire) e = exp_q.pop_front();
      if (exp_strobe) begin
        exp_q.push_back({model_val(f_ra), model_val(f_rb), f_rd, f_wr});
        have_fetch = 0;
      end
      if (in_valid && exp_ready) begin
        have_fetch = 1;
        f_ra = in_ra; f_rb = in_rb; f_rd = in_rd; f_wr = in_wr;
      end
      if (wb_valid) begin
        pend[wb_addr] = 0;
        if (wb_addr != 5'd0) arch[wb_addr] = wb_data;
      end
      if (retire && e[0] && e[5:1] != 5'd0) pend[e[5:1]] = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [4:0] a, input logic [15:0] d);
    wb_valid = 1; wb_addr = a; wb_data = d;
    tick();
    wb_valid = 0;
  endtask

  task automatic issue(input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rd, input logic wr);
    bit ok;
    ok = 0;
    in_valid = 1; in_ra = ra; in_rb = rb; in_rd = rd; in_wr = wr;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    in_valid = 0;
    if (!ok) chk("issue_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic retire_one();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int sa, sb0;
    reset = 0; in_valid = 0; in_ra = 0; in_rb = 0; in_rd = 0; in_wr = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
    repeat (3) tick();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_rd", out_rd, 0);
    chk("reset_out_wr", out_wr, 0);
    reset = 1;
    tick();

    // Basic read of two written registers
    do_wb(5'd3, 16'h1234);
    do_wb(5'd4, 16'h0F0F);
    sa = str_a; sb0 = str_b;
    issue(5'd3, 5'd4, 5'd0, 1'b0);
    wait_valid(n);
    chk("lat_basic", n, 1);
    chk("basic_a", out_a, 16'h1234);
    chk("basic_b", out_b, 16'h0F0F);
    chk("strobe_a_once", str_a - sa, 1);
    chk("strobe_b_once", str_b - sb0, 1);
    retire_one();

    // Pending write on r5 stalls a read; writeback releases it with forwarding
    issue(5'd1, 5'd2, 5'd5, 1'b1);
    wait_valid(n);
    retire_one();
    issue(5'd5, 5'd0, 5'd6, 1'b0);
    repeat (3) tick();
    chk("stall_valid", out_valid, 0);
    chk("stall_strobe", rf_read_a, 0);
    wb_valid = 1; wb_addr = 5'd5; wb_data = 16'hBEEF;
    #1;
    chk("release_strobe", rf_read_a, 1);
    tick();
    wb_valid = 0;
    chk("fwd_valid", out_valid, 1);
    chk("fwd_a", out_a, 16'hBEEF);
    chk("fwd_b", out_b, 16'h0000);
    retire_one();
    issue(5'd5, 5'd5, 5'd0, 1'b0);
    wait_valid(n);
    chk("lat_sb_cleared", n, 1);
    chk("r5_from_rf", out_b, 16'hBEEF);
    retire_one();

    // r0 is never written and always reads zero
    wb_valid = 1; wb_addr = 5'd0; wb_data = 16'hFFFF;
    #1;
    chk("r0_no_write", rf_write, 0);
    tick();
    wb_valid = 0;
    issue(5'd0, 5'd0, 5'd0, 1'b0);
    wait_valid(n);
    chk("lat_r0", n, 1);
    chk("r0_a", out_a, 16'h0000);
    chk("r0_b", out_b, 16'h0000);
    retire_one();

    // Backpressure in VALID, then scoreboard set on r9
    issue(5'd3, 5'd4, 5'd9, 1'b1);
    wait_valid(n);
    repeat (4) begin
      tick();
      chk("hold_in_ready", in_ready, 0);
      chk("hold_a", out_a, 16'h1234);
      chk("hold_rd", out_rd, 5'd9);
    end
    retire_one();
    chk("idle_after_hold", in_ready, 1);
    issue(5'd0, 5'd9, 5'd10, 1'b0);
    repeat (2) tick();
    chk("r9_stall", out_valid, 0);
    do_wb(5'd9, 16'h0909);
    wait_valid(n);
    chk("r9_fwd_b", out_b, 16'h0909);
    retire_one();

    // Same-cycle set and clear of r7: set wins
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    wait_valid(n);
    out_ready = 1; wb_valid = 1; wb_addr = 5'd7; wb_data = 16'h7777;
    tick();
    out_ready = 0; wb_valid = 0;
    issue(5'd7, 5'd0, 5'd0, 1'b0);
    repeat (3) tick();
    chk("r7_stall", out_valid, 0);
    chk("r7_stall_strobe", rf_read_a, 0);

    // Reset during the stall discards the instruction and the pending write
    reset = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_strobe", rf_read_a, 0);
    chk("midrst_out_a", out_a, 0);
    tick();
    tick();
    reset = 1;
    tick();
    issue(5'd7, 5'd3, 5'd0, 1'b0);
    wait_valid(n);
    chk("lat_after_rst", n, 1);
    chk("r7_after_rst", out_a, 16'h7777);
    chk("r3_after_rst", out_b, 16'h1234);
    retire_one();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
